// File: rtl/sb_sim_pkg.sv
// Shared definitions for the switchboard simulation source.
// - SBDW: widest payload the switchboard carries.
// - valid_mode_e: output valid gating modes.
// - LFSR_TAPS / lfsr_next: Galois LFSR used by the random valid mode.
package sb_sim_pkg;

  localparam int unsigned SBDW = 416;

  typedef enum logic [1:0] {
    VALID_MODE_ALT      = 2'd0,
    VALID_MODE_ALWAYS   = 2'd1,
    VALID_MODE_RANDOM   = 2'd2,
    VALID_MODE_THROTTLE = 2'd3
  } valid_mode_e;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

  // Any raw mode value outside 0..3 behaves like the always-open mode.
  function automatic valid_mode_e decode_mode(input logic [31:0] raw);
    if (raw[31:2] != '0) begin
      return VALID_MODE_ALWAYS;
    end
    return valid_mode_e'(raw[1:0]);
  endfunction

endpackage

// File: rtl/sb_sim_fifo.sv
// First-word-fall-through FIFO used as the prefetch buffer.
// Ports:
//   clk, nreset      clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata      write request and data (ignored when full)
//   pop              remove head (ignored when empty)
//   rdata            current head; all zeros while empty
//   count            occupancy 0..DEPTH, combinational from the pointers
//   full, empty      occupancy flags
module sb_sim_fifo
  import sb_sim_pkg::*;
#(
  parameter int unsigned WIDTH = SBDW + 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/queue_to_sb_fifo_sim.sv
// Switchboard source: pulls packets from a host-side queue into a DEPTH-entry
// prefetch FIFO and presents the head on a ready/valid SB port.
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   data/dest/last       head packet (zero while the FIFO is empty)
//   ready, valid         downstream handshake
//   level                FIFO occupancy 0..DEPTH
//   pkt_count            completed handshakes (wraps)
//   rx_id                queue connection id; all-ones means not connected
//   rx_recv              one queue receive call is made at this posedge
//   rx_success/rx_*      receive result: packet present, payload, dest, last
//   mode_we/mode_wdata   set the valid mode, effective from the next posedge
module queue_to_sb_fifo_sim
  import sb_sim_pkg::*;
#(
  parameter int unsigned DW                 = 416,
  parameter int unsigned DEPTH              = 4,
  parameter logic [31:0] VALID_MODE_DEFAULT = 32'd0,
  parameter int unsigned THROTTLE           = 4,
  parameter logic [31:0] LFSR_SEED          = 32'h1
) (
  input  logic                    clk,
  input  logic                    nreset,
  output logic [DW-1:0]           data,
  output logic [31:0]             dest,
  output logic                    last,
  input  logic                    ready,
  output logic                    valid,
  output logic [$clog2(DEPTH):0]  level,
  output logic [31:0]             pkt_count,
  input  logic [31:0]             rx_id,
  output logic                    rx_recv,
  input  logic                    rx_success,
  input  logic [SBDW-1:0]         rx_data,
  input  logic [31:0]             rx_dest,
  input  logic                    rx_last,
  input  logic                    mode_we,
  input  logic [31:0]             mode_wdata
);

  localparam int unsigned FW      = DW + 33;
  localparam int unsigned LW      = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [31:0]   TH_MAX  = 32'(THROTTLE - 1);

  logic [FW-1:0] wdata, rdata;
  logic          full, empty, push, xfer, avail, gate;
  logic [LW-1:0] level_after_pop;
  valid_mode_e   mode_eff;

  logic          valid_q, valid_d;
  logic [31:0]   pkt_count_q, pkt_count_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [31:0]   thr_q, thr_d;
  logic [31:0]   mode_q, mode_d;

  sb_sim_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (push),
    .wdata  (wdata),
    .pop    (xfer),
    .rdata  (rdata),
    .count  (level),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    // Poll only when connected and there is room before any pop this cycle.
    rx_recv  = nreset && (rx_id != '1) && !full;
    push     = rx_recv && rx_success;
    wdata    = {rx_last, rx_dest, rx_data[DW-1:0]};

    xfer     = valid_q && ready;
    // Only entries already buffered before this edge may raise valid, which
    // keeps a freshly fetched packet invisible for one more cycle.
    level_after_pop = xfer ? level - LVL_ONE : level;
    avail    = (level_after_pop != '0);

    mode_d   = mode_we ? mode_wdata : mode_q;
    lfsr_d   = lfsr_next(lfsr_q);
    if (xfer) begin
      thr_d = '0;
    end else if (thr_q == TH_MAX) begin
      thr_d = thr_q;
    end else begin
      thr_d = thr_q + 32'd1;
    end

    mode_eff = decode_mode(mode_q);
    case (mode_eff)
      VALID_MODE_ALT:      gate = !xfer;
      VALID_MODE_ALWAYS:   gate = 1'b1;
      VALID_MODE_RANDOM:   gate = lfsr_q[0];
      // Looking at the next counter value lets the transfer land exactly
      // THROTTLE cycles after the previous one.
      VALID_MODE_THROTTLE: gate = (thr_d == TH_MAX);
      default:             gate = 1'b1;
    endcase

    valid_d     = (valid_q && !xfer) || (avail && gate);
    pkt_count_d = xfer ? pkt_count_q + 32'd1 : pkt_count_q;

    valid     = valid_q;
    pkt_count = pkt_count_q;
    data      = rdata[DW-1:0];
    dest      = rdata[DW +: 32];
    last      = rdata[FW-1];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_q     <= 1'b0;
      pkt_count_q <= '0;
      lfsr_q      <= LFSR_SEED;
      thr_q       <= '0;
      mode_q      <= VALID_MODE_DEFAULT;
    end else begin
      valid_q     <= valid_d;
      pkt_count_q <= pkt_count_d;
      lfsr_q      <= lfsr_d;
      thr_q       <= thr_d;
      mode_q      <= mode_d;
    end
  end

endmodule

// File: tb/tb_queue_to_sb_fifo_sim.sv
module tb_queue_to_sb_fifo_sim;
  localparam int unsigned DW       = 416;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned THROTTLE = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic [31:0]   dest;
    logic          last;
  } pkt_t;

  typedef struct {
    int unsigned mode;
    int unsigned npkts;
    int unsigned gap;
  } scen_t;

  logic          clk = 1'b0;
  logic          nreset;
  logic [DW-1:0] data;
  logic [31:0]   dest;
  logic          last;
  logic          ready;
  logic          valid;
  logic [2:0]    level;
  logic [31:0]   pkt_count;
  logic [31:0]   rx_id;
  logic          rx_recv;
  logic          rx_success;
  logic [415:0]  rx_data;
  logic [31:0]   rx_dest;
  logic          rx_last;
  logic          mode_we;
  logic [31:0]   mode_wdata;

  queue_to_sb_fifo_sim #(
    .DW                 (DW),
    .DEPTH              (DEPTH),
    .VALID_MODE_DEFAULT (32'd0),
    .THROTTLE           (THROTTLE),
    .LFSR_SEED          (32'h1)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .data       (data),
    .dest       (dest),
    .last       (last),
    .ready      (ready),
    .valid      (valid),
    .level      (level),
    .pkt_count  (pkt_count),
    .rx_id      (rx_id),
    .rx_recv    (rx_recv),
    .rx_success (rx_success),
    .rx_data    (rx_data),
    .rx_dest    (rx_dest),
    .rx_last    (rx_last),
    .mode_we    (mode_we),
    .mode_wdata (mode_wdata)
  );

  always #5 clk = ~clk;

  // Reference: host queue, prefetch buffer contents, handshake count.
  pkt_t        src_q[$];
  pkt_t        mdl_q[$];
  logic [31:0] exp_cnt;
  int unsigned cur_mode;
  int unsigned cycle;
  int unsigned xfer_cycles[$];
  int unsigned n_tests, n_fail;

  function automatic logic [448:0] pack(input pkt_t p);
    return {p.last, p.dest, p.d};
  endfunction

  task automatic chk(input string name, input logic [448:0] act, input logic [448:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: cycle budget expired (actual delivered %0d)", name, exp_cnt);
  endtask

  task automatic drive_rx();
    if (src_q.size() > 0) begin
      rx_success = 1'b1;
      rx_data    = src_q[0].d;
      rx_dest    = src_q[0].dest;
      rx_last    = src_q[0].last;
    end else begin
      rx_success = 1'b0;
      rx_data    = '0;
      rx_dest    = '0;
      rx_last    = 1'b0;
    end
  endtask

  task automatic load(input int unsigned n, input bit rnd);
    pkt_t p;
    for (int unsigned k = 0; k < n; k++) begin
      p.d = '0;
      if (rnd) begin
        for (int unsigned w = 0; w < DW / 32; w++) p.d[w*32 +: 32] = $urandom;
        p.dest = $urandom;
        p.last = 1'($urandom_range(0, 1));
      end else begin
        p.d[31:0] = 32'hA000 + k;
        p.dest    = k + 1;
        p.last    = (k == n - 1);
      end
      src_q.push_back(p);
    end
    drive_rx();
  endtask

  // One clock: decide handshake/fetch before the edge, update the model,
  // then compare the DUT state just after the edge.
  task automatic step();
    logic        took, xf, pv;
    int unsigned pre;
    pkt_t        p;
    @(negedge clk);
    took = rx_recv && rx_success;
    xf   = valid && ready;
    pv   = valid;
    pre  = mdl_q.size();
    chk("recv", rx_recv, nreset && (rx_id != 32'hFFFFFFFF) && (pre < DEPTH));
    if (xf && pre == 0) chk("xfer_on_empty", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    cycle++;
    if (xf && pre > 0) begin
      void'(mdl_q.pop_front());
      exp_cnt++;
      xfer_cycles.push_back(cycle);
    end
    if (took && src_q.size() > 0) begin
      p = src_q.pop_front();
      mdl_q.push_back(p);
    end
    drive_rx();
    chk("level", level, mdl_q.size());
    chk("pkt_count", pkt_count, exp_cnt);
    chk("head", {last, dest, data}, (mdl_q.size() > 0) ? pack(mdl_q[0]) : '0);
    if (pv && !xf) chk("valid_hold", valid, 1'b1);
    if (!pv && valid) chk("rise_needs_buffered", (pre > 0), 1'b1);
    if (cur_mode == 0 && xf) chk("alt_gap", valid, 1'b0);
  endtask

  task automatic set_mode(input int unsigned m);
    mode_we    = 1'b1;
    mode_wdata = m;
    step();
    mode_we    = 1'b0;
    cur_mode   = m;
  endtask

  task automatic run_until(input logic [31:0] target, input int unsigned budget, input string name);
    int unsigned n;
    n = 0;
    while (exp_cnt < target && n < budget) begin
      step();
      n++;
    end
    if (exp_cnt < target) bound_fail(name);
  endtask

  scen_t       tbl[4];
  logic [31:0] base;
  int unsigned n;

  initial begin
    n_tests = 0; n_fail = 0; exp_cnt = '0; cur_mode = 0; cycle = 0;
    nreset = 1'b0; ready = 1'b0; rx_id = 32'hFFFFFFFF;
    mode_we = 1'b0; mode_wdata = '0;
    drive_rx();

    tbl[0] = '{mode: 1, npkts: 3, gap: 1};
    tbl[1] = '{mode: 0, npkts: 8, gap: 2};
    tbl[2] = '{mode: 3, npkts: 8, gap: THROTTLE};
    tbl[3] = '{mode: 6, npkts: 6, gap: 1};

    // Reset state
    #12;
    chk("rst_valid", valid, 1'b0);
    chk("rst_head", {last, dest, data}, '0);
    chk("rst_level", level, 0);
    chk("rst_pkt_count", pkt_count, 0);
    @(posedge clk); #1;
    nreset = 1'b1;
    #1;
    chk("recv_unconnected", rx_recv, 1'b0);
    rx_id = 32'd5;
    step();

    // Mode scenarios with a continuous stream and ready held high
    ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      set_mode(tbl[i].mode);
      base = exp_cnt;
      xfer_cycles.delete();
      load(tbl[i].npkts, 1'b0);
      run_until(base + tbl[i].npkts, 200, "scenario_delivery");
      chk("scenario_count", exp_cnt - base, tbl[i].npkts);
      for (int unsigned j = 1; j < xfer_cycles.size(); j++)
        chk("scenario_gap", xfer_cycles[j] - xfer_cycles[j-1], tbl[i].gap);
      if (i == 0) begin
        chk("first3_pkt_count", pkt_count, 32'd3);
        chk("first3_level", level, 0);
      end
      for (int unsigned j = 0; j < 3; j++) step();
    end

    // Backpressure: buffer saturates, remainder stays queued, nothing lost
    set_mode(1);
    ready = 1'b0;
    load(10, 1'b0);
    for (int unsigned j = 0; j < 20; j++) step();
    chk("bp_level", level, DEPTH);
    chk("bp_queue_left", src_q.size(), 6);
    chk("bp_valid", valid, 1'b1);
    ready = 1'b1;
    base = exp_cnt - 0;
    run_until(exp_cnt + 10, 100, "bp_drain");
    chk("bp_queue_empty", src_q.size(), 0);
    for (int unsigned j = 0; j < 3; j++) step();

    // Random valid mode with random ready and random payloads
    set_mode(2);
    load(40, 1'b1);
    base = exp_cnt;
    n = 0;
    while (exp_cnt < base + 40 && n < 3000) begin
      ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    if (exp_cnt < base + 40) bound_fail("random_delivery");
    ready = 1'b1;
    for (int unsigned j = 0; j < 3; j++) step();

    // Asynchronous reset while three packets are buffered and valid is high
    set_mode(1);
    ready = 1'b0;
    load(3, 1'b0);
    n = 0;
    while (!(mdl_q.size() == 3 && valid) && n < 20) begin
      step();
      n++;
    end
    chk("pre_reset_level", level, 3);
    chk("pre_reset_valid", valid, 1'b1);
    load(1, 1'b0);
    nreset = 1'b0;
    #1;
    chk("async_rst_valid", valid, 1'b0);
    chk("async_rst_level", level, 0);
    chk("async_rst_pkt_count", pkt_count, 0);
    mdl_q.delete();
    exp_cnt  = '0;
    cur_mode = 0;
    step();
    step();
    nreset = 1'b1;
    ready  = 1'b1;
    run_until(32'd1, 20, "post_reset_delivery");
    chk("post_reset_pkt_count", pkt_count, 32'd1);
    chk("post_reset_queue_empty", src_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
